// File: rtl/invsbox_round_ctrl.sv
//==============================================================================
// Module   : invsbox_round_ctrl
// Purpose  : Iterative inverse-S-box round controller for the 64-bit decrypt
//            path; one shared 32-bit inverse S-box, two cycles per round.
// Options  : INVSBOX_CTRL_PARITY_EN adds the dataParity output.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module invsbox (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    logic [3:0] w_nib;

    always_comb begin
      w_nib = 4'h0;
      case (i_word[gi*4 +: 4])
        4'h0: w_nib = 4'hA;
        4'h1: w_nib = 4'hB;
        4'h2: w_nib = 4'h3;
        4'h3: w_nib = 4'h6;
        4'h4: w_nib = 4'hD;
        4'h5: w_nib = 4'h4;
        4'h6: w_nib = 4'h7;
        4'h7: w_nib = 4'h8;
        4'h8: w_nib = 4'hF;
        4'h9: w_nib = 4'h1;
        4'hA: w_nib = 4'hC;
        4'hB: w_nib = 4'hE;
        4'hC: w_nib = 4'h0;
        4'hD: w_nib = 4'h2;
        4'hE: w_nib = 4'h9;
        4'hF: w_nib = 4'h5;
        default: w_nib = 4'h0;
      endcase
    end

    assign o_word[gi*4 +: 4] = w_nib;
  end

endmodule

module invsbox_round_ctrl #(
  parameter int ROUNDS = 4,
  parameter int CNT_W  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] dataIn,
  input  logic [63:0] keyIn,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dataOut,
  output logic        busy
`ifdef INVSBOX_CTRL_PARITY_EN
  ,
  output logic        dataParity
`endif
);

  localparam logic [1:0] c_stIdle = 2'd0;
  localparam logic [1:0] c_stHi   = 2'd1;
  localparam logic [1:0] c_stLo   = 2'd2;
  localparam logic [1:0] c_stDone = 2'd3;

  localparam logic [CNT_W-1:0] c_lastRound = CNT_W'(ROUNDS - 1);

  logic [1:0]       r_state;
  logic [63:0]      r_stateReg;
  logic [63:0]      r_keyReg;
  logic [CNT_W-1:0] r_roundCnt;

  logic [31:0] w_sboxIn;
  logic [31:0] w_sboxOut;
  logic        w_lastLo;

  // The single S-box sees the hi half in HI and the lo half otherwise.
  assign w_sboxIn = (r_state == c_stHi) ? (r_stateReg[63:32] ^ r_keyReg[63:32])
                                        : (r_stateReg[31:0]  ^ r_keyReg[31:0]);

  invsbox u_invsbox (
    .i_word (w_sboxIn),
    .o_word (w_sboxOut)
  );

  assign w_lastLo  = (r_state == c_stLo) && (r_roundCnt == c_lastRound);

  assign in_ready  = (r_state == c_stIdle);
  assign out_valid = (r_state == c_stDone);
  assign busy      = (r_state == c_stHi) || (r_state == c_stLo);
  assign dataOut   = r_stateReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_stIdle;
      r_stateReg <= 64'h0;
      r_keyReg   <= 64'h0;
      r_roundCnt <= '0;
    end else if (abort) begin
      r_state    <= c_stIdle;
      r_roundCnt <= '0;
    end else begin
      case (r_state)
        c_stIdle: begin
          if (in_valid) begin
            r_stateReg <= dataIn;
            r_keyReg   <= keyIn;
            r_roundCnt <= '0;
            r_state    <= c_stHi;
          end
        end
        c_stHi: begin
          r_stateReg[63:32] <= w_sboxOut;
          r_state           <= c_stLo;
        end
        c_stLo: begin
          // Substituted lo moves up, the hi half finished last cycle moves down.
          r_stateReg <= {w_sboxOut, r_stateReg[63:32]};
          if (r_roundCnt == c_lastRound) begin
            r_state <= c_stDone;
          end else begin
            r_roundCnt <= r_roundCnt + 1'b1;
            r_state    <= c_stHi;
          end
        end
        c_stDone: begin
          if (out_ready) begin
            r_state <= c_stIdle;
          end
        end
        default: r_state <= c_stIdle;
      endcase
    end
  end

`ifdef INVSBOX_CTRL_PARITY_EN
  logic r_dataParity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dataParity <= 1'b0;
    end else if (abort) begin
      r_dataParity <= 1'b0;
    end else if (w_lastLo) begin
      r_dataParity <= ^{w_sboxOut, r_stateReg[63:32]};
    end else if ((r_state == c_stDone) && out_ready) begin
      r_dataParity <= 1'b0;
    end
  end

  assign dataParity = r_dataParity;
`endif

endmodule

`default_nettype wire

// File: doc/invsbox_round_ctrl.md
Name: invsbox_round_ctrl

Overview:
- Iterative inverse-substitution round controller for the 64-bit decryption path.
- Owns a single instance of the existing 32-bit inverse S-box datapath and time-shares it between the high and low halves of the state: one half per cycle, two cycles per round.
- Sequences ROUNDS rounds of key-XOR, inverse substitution and half-swap.
- Accepts blocks through a valid/ready input handshake and returns results through a valid/ready output handshake.

Parameters:
ROUNDS, 4, number of rounds per block; legal range 1..31
CNT_W, 5, round counter width; must satisfy 2^CNT_W > ROUNDS

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input block and key are presented
in_ready  output  1  controller can accept a block
dataIn  input  64  ciphertext block; [63:32] = hi half, [31:0] = lo half
keyIn  input  64  round key, latched with the block and used for every round
abort  input  1  synchronous soft clear
out_valid  output  1  dataOut holds a finished result
out_ready  input  1  consumer accepts the result
dataOut  output  64  result block; equals the state register
busy  output  1  high in HI or LO state

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; stateReg=0, keyReg=0, roundCnt=0.
  - out_valid=0, busy=0, dataOut=0.
  - in_ready=1, because in_ready is combinational (state==IDLE). No block is accepted while rst_n=0.
- Shared S-box:
  - One invsbox instance. Its input is (hi^keyHi) in HI and (lo^keyLo) in LO, selected by state.
  - Nibble map, for verification: 0>A 1>B 2>3 3>6 4>D 5>4 6>7 7>8 8>F 9>1 A>C B>E C>0 D>2 E>9 F>5.
- States:
  - IDLE: in_ready=1. When in_valid=1, on the clock edge: stateReg<=dataIn, keyReg<=keyIn, roundCnt<=0, go to HI.
  - HI: stateReg[63:32] <= invS(stateReg[63:32]^keyReg[63:32]); go to LO.
  - LO: stateReg <= {invS(stateReg[31:0]^keyReg[31:0]), stateReg[63:32]}. This uses the hi half just updated in HI, so the halves swap. Then:
    - if roundCnt==ROUNDS-1: go to DONE;
    - otherwise: roundCnt<=roundCnt+1 and go to HI.
  - DONE: out_valid=1 and dataOut is held stable. When out_ready=1, go to IDLE on the edge. in_ready=0 in DONE, so an input block cannot be accepted in the same cycle as the result handoff.
- Latency:
  - out_valid rises exactly 2*ROUNDS clock edges after the accepting edge.
  - Throughput is one block per 2*ROUNDS+2 cycles when out_ready is tied high.
- abort:
  - From any state: go to IDLE next edge, out_valid=0, roundCnt=0. stateReg and keyReg are left unchanged.
  - abort together with in_valid in IDLE: abort wins and the block is not accepted.
  - abort in DONE together with out_ready: the result is dropped and the handoff is not counted.
- Stability:
  - in_valid, dataIn and keyIn are sampled only on the accepting edge; later changes have no effect.
  - out_ready is ignored outside DONE.
- Reset mid-operation: every register returns to its reset value immediately. No partial output appears after rst_n is released.
- Counter: roundCnt never exceeds ROUNDS-1. There is no wrap-around; ROUNDS out of range is a configuration error.

Optional Feature:
- Macro: INVSBOX_CTRL_PARITY_EN.
- When defined:
  - Adds output port dataParity (1 bit), which equals the XOR-reduction of dataOut while out_valid=1 and is 0 otherwise.
  - dataParity is registered together with the entry into DONE and resets to 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- ROUNDS=1, dataIn=0x0123456789ABCDEF, keyIn=0 -> out_valid 2 edges after accept, dataOut=0xF1CE0295AB36D478.
- ROUNDS=4, dataIn=0, keyIn=0 -> dataOut=0xAAAAAAAAAAAAAAAA after 8 edges; busy high for exactly 8 cycles.
- ROUNDS=1, dataIn=0, keyIn=0xFFFFFFFFFFFFFFFF -> dataOut=0x5555555555555555; with INVSBOX_CTRL_PARITY_EN, keyIn=0x0000000000000001 -> dataOut=0xAAAAAAABAAAAAAAA and dataParity=1.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and dataOut stay stable and in_ready=0; raise out_ready -> IDLE next edge and in_ready=1.
- Pulse abort in the second HI state with ROUNDS=4 -> IDLE next edge, out_valid never rises; a new block accepted afterwards completes correctly.
- Drop rst_n during LO of round 2 -> outputs go to reset values immediately; after release, dataIn=0 and keyIn=0 give 0xAAAAAAAAAAAAAAAA with ROUNDS=4.
